index_scatter_vector: RTL and testbench



---
 rtl/index_scatter_vector_pkg.sv | 24 ++
 rtl/index_scatter_vector_mask_tracker.sv | 50 +++++
 rtl/index_scatter_vector.sv | 92 +++++++++
 tb/tb_index_scatter_vector.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/index_scatter_vector_pkg.sv
// Shared types and helpers for the indexed scatter-to-vector assembler.
package index_scatter_vector_pkg;

  localparam int unsigned ELEM_BITS = 16;
  localparam int unsigned MAX_N     = 64;

  typedef logic [ELEM_BITS-1:0] elem_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } scatter_state_e;

  // True when the low n bits of mask are all set.
  function automatic logic all_ones(input logic [MAX_N-1:0] mask, input int unsigned n);
    logic r;
    r = 1'b1;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (i < n && !mask[i]) r = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/index_scatter_vector_mask_tracker.sv
// Tracks which vector positions were written this frame, repeat writes, and frame completion.
module scatter_mask_tracker
  import index_scatter_vector_pkg::*;
#(
  parameter int unsigned N          = 3,
  parameter int unsigned INDEX_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic                  clear,
  output logic [N-1:0]          mask,
  output logic                  dup,
  output logic                  full_c
);

  logic [N-1:0] r_mask;
  logic         r_dup;
  logic [N-1:0] w_mask_nxt;
  logic         w_hit_dup;

  always_comb begin
    w_mask_nxt = r_mask;
    w_hit_dup  = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (wr_en && wr_idx == INDEX_BITS'(i)) begin
        w_hit_dup     = r_mask[i];
        w_mask_nxt[i] = 1'b1;
      end
    end
  end

  // Completion is judged on the mask as it will look after this write.
  assign full_c = wr_en && all_ones(MAX_N'(w_mask_nxt), N);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_mask <= '0;
      r_dup  <= 1'b0;
    end else begin
      r_mask <= w_mask_nxt;
      if (w_hit_dup) r_dup <= 1'b1;
    end
  end

  assign mask = r_mask;
  assign dup  = r_dup;

endmodule

// File: rtl/index_scatter_vector.sv
// Assembles (index, value) write beats into an N-element vector and presents it with a written-mask.
module index_scatter_vector
  import index_scatter_vector_pkg::scatter_state_e;
#(
  parameter int unsigned    BITS       = 16,
  parameter int unsigned    INDEX_BITS = 4,
  parameter int unsigned    N          = 3,
  parameter logic [BITS-1:0] FILL      = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [INDEX_BITS-1:0] index,
  input  logic [BITS-1:0]       a,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BITS-1:0]       vector_c [N],
  output logic [N-1:0]          mask,
  output logic                  dup,
  output logic                  err
);

  scatter_state_e  r_state;
  scatter_state_e  w_state_nxt;
  logic [BITS-1:0] r_vec [N];
  logic            r_err;
  logic            w_accept;
  logic            w_idx_ok;
  logic            w_wr_en;
  logic            w_clear;
  logic            w_full_c;

  assign in_ready  = (r_state == index_scatter_vector_pkg::FILL);
  assign out_valid = (r_state == index_scatter_vector_pkg::HOLD);
  assign w_accept  = in_valid && in_ready;
  assign w_idx_ok  = 32'(index) < N;
  assign w_wr_en   = w_accept && w_idx_ok;
  assign w_clear   = out_valid && out_ready;

  scatter_mask_tracker #(
    .N          (N),
    .INDEX_BITS (INDEX_BITS)
  ) u_tracker (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (w_wr_en),
    .wr_idx (index),
    .clear  (w_clear),
    .mask   (mask),
    .dup    (dup),
    .full_c (w_full_c)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= index_scatter_vector_pkg::FILL;
    else     r_state <= w_state_nxt;
  end

  // A frame closes on the beat that fills the last position or carries in_last.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      index_scatter_vector_pkg::FILL:
        if (w_accept && (w_full_c || in_last)) w_state_nxt = index_scatter_vector_pkg::HOLD;
      index_scatter_vector_pkg::HOLD:
        if (out_ready) w_state_nxt = index_scatter_vector_pkg::FILL;
      default: w_state_nxt = index_scatter_vector_pkg::FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      for (int i = 0; i < int'(N); i++) r_vec[i] <= FILL;
    end else if (w_wr_en) begin
      for (int i = 0; i < int'(N); i++) begin
        if (index == INDEX_BITS'(i)) r_vec[i] <= a;
      end
    end
  end

  // Out-of-range index flags a single-cycle error; the beat is otherwise dropped.
  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_accept && !w_idx_ok;
  end

  assign vector_c = r_vec;
  assign err      = r_err;

endmodule

// File: tb/tb_index_scatter_vector.sv
// Self-checking bench for index_scatter_vector: frame table plus scoreboard of assembled vectors.
module tb_index_scatter_vector;
  import index_scatter_vector_pkg::*;

  typedef struct packed {
    logic [2:0][15:0] v;
    logic [2:0]       m;
    logic             d;
  } exp_t;

  typedef struct {
    int               nb;
    logic [3:0][3:0]  idx;
    logic [3:0][15:0] dat;
    logic [3:0]       last;
    exp_t             e;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [3:0]  index;
  elem_t       a;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] vector_c [3];
  logic [2:0]  mask;
  logic        dup;
  logic        err;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t q[$];
  exp_t mon_e;
  frame_t fr [5];

  index_scatter_vector #(
    .BITS(16), .INDEX_BITS(4), .N(3), .FILL(16'd0)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .index(index), .a(a), .out_valid(out_valid),
    .out_ready(out_ready), .vector_c(vector_c), .mask(mask), .dup(dup), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic frame_t mkf(input int nb,
      input logic [3:0] i0, input logic [3:0] i1, input logic [3:0] i2, input logic [3:0] i3,
      input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] d3,
      input logic [3:0] last,
      input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
      input logic [2:0] m, input logic d);
    frame_t r;
    r.nb = nb;
    r.idx[0] = i0; r.idx[1] = i1; r.idx[2] = i2; r.idx[3] = i3;
    r.dat[0] = d0; r.dat[1] = d1; r.dat[2] = d2; r.dat[3] = d3;
    r.last = last;
    r.e.v[0] = e0; r.e.v[1] = e1; r.e.v[2] = e2;
    r.e.m = m;
    r.e.d = d;
    return r;
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send(input logic [3:0] i, input logic [15:0] d, input logic l);
    int t;
    in_valid = 1'b1; index = i; a = d; in_last = l;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
    chk({tag, "_mask"},      64'(mask),      64'd0);
    chk({tag, "_dup"},       64'(dup),       64'd0);
    for (int i = 0; i < 3; i++) chk($sformatf("%s_vec%0d", tag, i), 64'(vector_c[i]), 64'd0);
  endtask

  // Scoreboard: compare each handed-off vector with the oldest expected record.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 64'd1, 64'd0);
      end else begin
        mon_e = q.pop_front();
        for (int i = 0; i < 3; i++) chk($sformatf("vector_c[%0d]", i), 64'(vector_c[i]), 64'(mon_e.v[i]));
        chk("mask", 64'(mask), 64'(mon_e.m));
        chk("dup",  64'(dup),  64'(mon_e.d));
      end
    end
  end

  initial begin
    fr[0] = mkf(3, 4'd2, 4'd0, 4'd1, 4'd0, 16'd7,  16'd5,  16'd9,  16'd0, 4'b0000, 16'd5,  16'd9,  16'd7, 3'b111, 1'b0);
    fr[1] = mkf(4, 4'd1, 4'd1, 4'd0, 4'd2, 16'd3,  16'd8,  16'd1,  16'd6, 4'b0000, 16'd1,  16'd8,  16'd6, 3'b111, 1'b1);
    fr[2] = mkf(2, 4'd1, 4'd0, 4'd0, 4'd0, 16'd4,  16'd2,  16'd0,  16'd0, 4'b0010, 16'd2,  16'd4,  16'd0, 3'b011, 1'b0);
    fr[3] = mkf(3, 4'd0, 4'd0, 4'd1, 4'd0, 16'd10, 16'd11, 16'd12, 16'd0, 4'b0100, 16'd11, 16'd12, 16'd0, 3'b011, 1'b1);
    fr[4] = fr[2];

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; index = '0; a = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_cleared("reset");
    chk("reset_err", 64'(err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Frame table: one-cycle hand-off latency, then the block re-opens cleared.
    for (int f = 0; f < 5; f++) begin
      q.push_back(fr[f].e);
      for (int b = 0; b < fr[f].nb; b++) send(fr[f].idx[b], fr[f].dat[b], fr[f].last[b]);
      @(negedge clk);
      chk($sformatf("f%0d_out_valid", f), 64'(out_valid), 64'd1);
      chk($sformatf("f%0d_in_ready_hold", f), 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk_cleared($sformatf("f%0d_after", f));
      @(posedge clk); #1;
    end
    drain();

    // Out-of-range index: one-cycle err, no mask change; in_last still closes the frame.
    send(4'd3, 16'd5, 1'b0);
    @(negedge clk);
    chk("oor_err_pulse", 64'(err), 64'd1);
    chk("oor_mask", 64'(mask), 64'd0);
    chk("oor_open", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("oor_err_low", 64'(err), 64'd0);
    @(posedge clk); #1;
    q.push_back('{v: '0, m: 3'b000, d: 1'b0});
    send(4'd3, 16'd0, 1'b1);
    @(negedge clk);
    chk("oor_last_err", 64'(err), 64'd1);
    chk("oor_last_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("oor_last_err_low", 64'(err), 64'd0);
    @(posedge clk); #1;
    drain();

    // Backpressure: held vector stays put while a new beat waits.
    out_ready = 1'b0;
    q.push_back(fr[0].e);
    for (int b = 0; b < 3; b++) send(fr[0].idx[b], fr[0].dat[b], 1'b0);
    in_valid = 1'b1; index = 4'd0; a = 16'd33; in_last = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_in_ready", k), 64'(in_ready), 64'd0);
      chk($sformatf("bp%0d_out_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("bp%0d_vec0", k), 64'(vector_c[0]), 64'd5);
      chk($sformatf("bp%0d_mask", k), 64'(mask), 64'd7);
      @(posedge clk); #1;
    end
    q.push_back('{v: {16'd2, 16'd1, 16'd33}, m: 3'b111, d: 1'b0});
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_reopen_in_ready", 64'(in_ready), 64'd1);
    chk("bp_reopen_mask", 64'(mask), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_pending_mask", 64'(mask), 64'd1);
    chk("bp_pending_vec0", 64'(vector_c[0]), 64'd33);
    @(posedge clk); #1;
    send(4'd1, 16'd1, 1'b0);
    send(4'd2, 16'd2, 1'b0);
    drain();

    // Reset while holding discards the vector.
    out_ready = 1'b0;
    send(4'd1, 16'd4, 1'b0);
    send(4'd0, 16'd2, 1'b1);
    @(negedge clk);
    chk("rh_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_cleared("rst_hold");
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Reset coincident with the completing beat wins.
    send(4'd0, 16'd4, 1'b0);
    send(4'd1, 16'd5, 1'b0);
    in_valid = 1'b1; index = 4'd2; a = 16'd6; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk_cleared("rst_beat");
    @(posedge clk); #1;

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
